// File: rtl/ram_stream_reader.sv
// Streams a contiguous address range out of a registered-read RAM as a valid/ready stream.
// Reads are credit-gated against a 2-entry skid FIFO, so RAM latency and backpressure never drop or duplicate a word.
module ram_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr_rd,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   issue_cnt_q, issue_cnt_d;
  logic [ADDR_WIDTH:0]   xfer_cnt_q, xfer_cnt_d;
  logic                  pending_q;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;
  logic                  push, pop, credit, issue;

  // addr_q drives the RAM directly, so an issue in cycle t returns data in t+1 (pending_q).
  assign ram_addr_rd = addr_q;
  assign out_valid   = (count_q != 2'd0);
  assign out_data    = fifo_q[rd_ptr_q];
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

  assign push   = pending_q;
  assign pop    = out_valid && out_ready;
  // A same-cycle pop frees a slot; pop implies count_q >= 1, so no underflow.
  assign credit = (({1'b0, count_q} + {2'b00, pending_q} - {2'b00, pop}) < 3'd2);
  assign issue  = (state_q == S_READ) && (issue_cnt_q != '0) && credit;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    xfer_cnt_d  = xfer_cnt_q;
    if (pop && xfer_cnt_q != '0) xfer_cnt_d = xfer_cnt_q - 1'b1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_READ;
            addr_d      = base_addr;
            issue_cnt_d = length;
            xfer_cnt_d  = length;
          end
        end
      end
      S_READ: begin
        if (issue) begin
          addr_d      = addr_q + 1'b1;
          issue_cnt_d = issue_cnt_q - 1'b1;
          if (issue_cnt_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (xfer_cnt_d == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      xfer_cnt_q  <= '0;
      pending_q   <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
      pending_q   <= issue;
      if (push) begin
        fifo_q[wr_ptr_q] <= ram_dout;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed jobs with randomized backpressure; expected words come from a queue built from base/length arithmetic.
module tb_ram_stream_reader;
  logic       clk, rst, start, out_ready;
  logic [3:0] base_addr, ram_addr_rd;
  logic [4:0] length;
  logic       busy, done, out_valid;
  logic [7:0] ram_dout, out_data;
  logic [7:0] mem [16];

  ram_stream_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_addr_rd(ram_addr_rd), .ram_dout(ram_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ram_dout <= mem[ram_addr_rd];

  int checks = 0, errors = 0;
  int cyc = 0, nxfer, ndone, cur_len, first_valid, last_xfer, done_cyc, start_cyc;
  logic [7:0] exp_q[$];
  logic [3:0] alog[$];
  logic       log_en = 1'b0, prev_hold = 1'b0;
  logic [7:0] prev_data;
  logic [5:0] pat = 6'b101001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs at the falling edge, then observe the registered outputs.
  task automatic step(input logic st, input logic rdy, input logic rs);
    @(negedge clk);
    start = st; out_ready = rdy; rst = rs; cyc++;
    if (prev_hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_data);
    end
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (out_valid && out_ready) begin
      nxfer++; last_xfer = cyc;
      if (exp_q.size() == 0) chk("extra_xfer", nxfer, cur_len);
      else chk("data", out_data, exp_q.pop_front());
    end
    prev_hold = out_valid && !out_ready && !rs;
    prev_data = out_data;
    if (done) begin
      ndone++; done_cyc = cyc;
      chk("busy_at_done", busy, 1);
    end
    if (busy && log_en && (alog.size() == 0 || alog[$] != ram_addr_rd)) alog.push_back(ram_addr_rd);
  endtask

  task automatic setup(input int base, input int len);
    exp_q.delete();
    for (int k = 0; k < len; k++) exp_q.push_back(8'(8'h10 + ((base + k) % 16)));
    cur_len = len; nxfer = 0; ndone = 0;
    first_valid = -1; last_xfer = -1; done_cyc = -1;
    base_addr = 4'(base); length = 5'(len);
  endtask

  // mode 0: ready held high, 1: 1,0,0,1,0,1 pattern with a 10-cycle stall, 2: random ready
  task automatic run_job(input int base, input int len, input int mode, input logic spam);
    logic rdy;
    int   hold_n = 0, pi = 0;
    logic held = 1'b0;
    setup(base, len);
    step(1'b1, 1'b1, 1'b0);
    start_cyc = cyc;
    for (int n = 0; n < 400 && ndone == 0; n++) begin
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) begin
        if (nxfer >= 2 && !held) begin held = 1'b1; hold_n = 10; end
        if (hold_n > 0) begin rdy = 1'b0; hold_n--; end
        else rdy = pat[pi % 6];
        pi++;
      end else rdy = 1'($urandom_range(0, 1));
      if (spam && n >= 1) begin base_addr = 4'd9; length = 5'd7; end
      step(spam, rdy, 1'b0);
    end
    if (ndone == 0) chk("timeout_done", ndone, 1);
    step(1'b0, 1'b1, 1'b0);
    chk("busy_after_done", busy, 0);
    for (int n = 0; n < 3; n++) step(1'b0, 1'b1, 1'b0);
    chk("done_count", ndone, 1);
    chk("xfer_count", nxfer, len);
    chk("exp_left", exp_q.size(), 0);
    chk("done_latency", done_cyc, (len == 0) ? start_cyc + 1 : last_xfer + 1);
    if (mode == 0 && len > 0) begin
      chk("first_valid", first_valid, start_cyc + 3);
      chk("last_xfer", last_xfer, start_cyc + 3 + len - 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 8'h10);
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; length = '0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_addr", ram_addr_rd, 0);

    run_job(2, 5, 0, 1'b0);

    alog.delete(); log_en = 1'b1;
    run_job(14, 4, 0, 1'b0);
    log_en = 1'b0;
    chk("addr_log_len", (alog.size() >= 4), 1);
    if (alog.size() >= 4) begin
      chk("addr0", alog[0], 14);
      chk("addr1", alog[1], 15);
      chk("addr2", alog[2], 0);
      chk("addr3", alog[3], 1);
    end

    run_job(2, 5, 1, 1'b0);
    run_job(5, 0, 0, 1'b0);
    run_job(4, 3, 0, 1'b1);

    // Abort a 6-word job after two transfers.
    setup(3, 6);
    step(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 50 && nxfer < 2; n++) step(1'b0, 1'b1, 1'b0);
    chk("pre_rst_xfers", nxfer, 2);
    step(1'b0, 1'b0, 1'b1);
    ndone = 0;
    for (int n = 0; n < 8; n++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
    end
    chk("abort_data", out_data, 0);
    chk("abort_done", ndone, 0);
    run_job(0, 2, 0, 1'b0);

    run_job(7, 16, 2, 1'b0);
    for (int r = 0; r < 3; r++) run_job(int'($urandom_range(0, 15)), int'($urandom_range(1, 16)), 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
